// File: rtl/handshake_constant_arbiter.sv
// Shared constant server: round-robin arbitration among NUM_REQ control channels,
// winner's constant and index delivered through one registered output slot.
module handshake_constant_arbiter #(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            NUM_REQ    = 4,
    parameter int                            TAG_WIDTH  = 2,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [TAG_WIDTH-1:0]  outs_tag,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [PW-1:0]         r_prio;

    logic [NUM_REQ-1:0]    w_valid;
    logic [NUM_REQ-1:0]    w_grant;
    logic [PW-1:0]         w_win;
    logic                  w_found;
    logic                  w_load;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_const;
    logic [PW-1:0]         w_prio_next;

    // Requests are masked while reset is held so no ready can leak out.
    assign w_valid    = rst ? {NUM_REQ{1'b0}} : ctrl_valid;
    assign w_load     = ~r_full | outs_ready;
    assign w_accept   = w_found & w_load;
    assign ctrl_ready = w_grant & {NUM_REQ{w_load}};

    assign outs       = r_data;
    assign outs_tag   = r_tag;
    assign outs_valid = r_full;

    // Round-robin search: requester i sits at offset k when prio+k wraps onto i.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && w_valid[i] &&
                    ((int'(r_prio) + k == i) || (int'(r_prio) + k == i + NUM_REQ))) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_win      = PW'(i);
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Constant selection for the winner and the pointer advance past it.
    always_comb begin
        w_const = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_const = CONSTS[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_const = w_const;
            end
        end
        if (w_win == PW'(NUM_REQ - 1)) begin
            w_prio_next = '0;
        end else begin
            w_prio_next = w_win + PW'(1);
        end
    end

    // Output slot and pointer; an accept takes precedence over a plain drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_tag  <= '0;
            r_prio <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= w_const;
            r_tag  <= TAG_WIDTH'(w_win);
            r_prio <= w_prio_next;
        end else if (outs_ready && r_full) begin
            r_full <= 1'b0;
        end else begin
            r_full <= r_full;
        end
    end

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed bench for handshake_constant_arbiter with 3 requesters and 10-bit constants.
module tb_handshake_constant_arbiter;

    localparam int DW = 10;
    localparam int NR = 3;
    localparam int TW = 2;
    localparam logic [NR*DW-1:0] K = {10'd1023, 10'd7, 10'b1110110110};

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] ctrl_valid;
    logic [NR-1:0] ctrl_ready;
    logic [DW-1:0] outs;
    logic [TW-1:0] outs_tag;
    logic          outs_valid;
    logic          outs_ready;

    int total = 0;
    int bad   = 0;

    handshake_constant_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_WIDTH(TW), .CONSTS(K)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .outs(outs), .outs_tag(outs_tag), .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [31:0] t,
                           input logic [31:0] v);
        chk({tag, "_outs"}, 32'(outs), d);
        chk({tag, "_tag"}, 32'(outs_tag), t);
        chk({tag, "_valid"}, 32'(outs_valid), v);
    endtask

    initial begin
        rst        = 1'b1;
        ctrl_valid = 3'b000;
        outs_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_valid", 32'(outs_valid), 32'd0);

        // Leave prio at 2 and the slot full before the mid-cycle reset.
        ctrl_valid = 3'b010;
        outs_ready = 1'b1;
        #1 chk("pre_ready", 32'(ctrl_ready), 32'd2);
        tick();
        chk_out("pre", 32'd7, 32'd1, 32'd1);

        ctrl_valid = 3'b111;
        #3 rst = 1'b1;
        #1;
        chk_out("rst", 32'd0, 32'd0, 32'd0);
        chk("rst_ready", 32'(ctrl_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(ctrl_ready), 32'd1);

        // Round-robin with all requesters active and a free consumer.
        tick();
        chk_out("rr0", 32'd950, 32'd0, 32'd1);
        chk("rr0_ready", 32'(ctrl_ready), 32'd2);
        tick();
        chk_out("rr1", 32'd7, 32'd1, 32'd1);
        chk("rr1_ready", 32'(ctrl_ready), 32'd4);
        tick();
        chk_out("rr2", 32'd1023, 32'd2, 32'd1);
        chk("rr_wrap_ready", 32'(ctrl_ready), 32'd1);
        tick();
        chk_out("rr3", 32'd950, 32'd0, 32'd1);

        // prio=1 with requesters 0 and 2: 1 is skipped, 2 wins, then 0.
        ctrl_valid = 3'b101;
        #1 chk("skip_ready", 32'(ctrl_ready), 32'd4);
        tick();
        chk_out("skip0", 32'd1023, 32'd2, 32'd1);
        chk("skip_next_ready", 32'(ctrl_ready), 32'd1);
        tick();
        chk_out("skip1", 32'd950, 32'd0, 32'd1);

        // Single requester back-to-back.
        ctrl_valid = 3'b010;
        for (int n = 0; n < 4; n++) begin
            #1 chk("b2b_ready", 32'(ctrl_ready), 32'd2);
            tick();
            chk_out("b2b", 32'd7, 32'd1, 32'd1);
        end

        // Backpressure on a full slot holding constant 2.
        ctrl_valid = 3'b100;
        tick();
        chk_out("bp_load", 32'd1023, 32'd2, 32'd1);
        ctrl_valid = 3'b001;
        outs_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1 chk("bp_ready", 32'(ctrl_ready), 32'd0);
            tick();
            chk_out("bp_hold", 32'd1023, 32'd2, 32'd1);
        end
        outs_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(ctrl_ready), 32'd1);
        tick();
        chk_out("bp_refill", 32'd950, 32'd0, 32'd1);

        // Drain without refill, then idle hold; prio stays at 1.
        ctrl_valid = 3'b000;
        #1 chk("drain_ready", 32'(ctrl_ready), 32'd0);
        tick();
        chk_out("drain", 32'd950, 32'd0, 32'd0);
        tick();
        chk_out("idle", 32'd950, 32'd0, 32'd0);
        ctrl_valid = 3'b111;
        #1 chk("prio_kept_ready", 32'(ctrl_ready), 32'd2);
        tick();
        chk_out("after_idle", 32'd7, 32'd1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/handshake_constant_arbiter.md
# handshake_constant_arbiter

Shared constant server for elastic dataflow circuits. NUM_REQ independent control channels each request their own compile-time constant. A round-robin arbiter picks one winner per cycle. The block emits the winner's constant, tagged with its requester index, through a single registered output channel. It replaces NUM_REQ separate constant units when the consumer is one shared port, such as a shared store-data or operand bus.

## Interface
Parameters:
- DATA_WIDTH, 32: width of each constant and of `outs`.
- NUM_REQ, 4: number of requester channels, at least 2.
- TAG_WIDTH, 2: width of `outs_tag`. Must be at least clog2(NUM_REQ).
- CONSTS, 0: flat vector of NUM_REQ*DATA_WIDTH bits. Constant i is CONSTS[i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- ctrl_valid, input, NUM_REQ: request valid, bit i belongs to requester i.
- ctrl_ready, output, NUM_REQ: request accepted, bit i belongs to requester i.
- outs, output, DATA_WIDTH: registered constant.
- outs_tag, output, TAG_WIDTH: index of the requester whose constant is in `outs`.
- outs_valid, output, 1: output register holds data.
- outs_ready, input, 1: consumer accepts.

## Operation
- State:
  - One output slot: `full`, `data_q`, `tag_q`.
  - Round-robin pointer `prio`, range 0..NUM_REQ-1.
- Slot availability: `load = ~full | outs_ready`.
- Grant (combinational):
  - The winner is the first i with ctrl_valid[i]=1, searching i = prio, prio+1, … modulo NUM_REQ.
  - At most one grant bit is set.
  - If no ctrl_valid bit is set, there is no grant.
- Ready: ctrl_ready[i] = grant[i] & load. Every non-granted bit is 0.
- Accept: a handshake occurs when some ctrl_valid[i] & ctrl_ready[i] is 1. On accept:
  - data_q <= constant i
  - tag_q <= i
  - full <= 1
  - prio <= (i+1) mod NUM_REQ
- Drain: when outs_ready & full and there is no accept, full <= 0. data_q and tag_q hold their values.
- prio changes only on an accept.
- Outputs: outs = data_q, outs_tag = tag_q, outs_valid = full.
- There is no combinational path from ctrl_valid to outs_valid, or from ctrl to outs. The output is fully registered.
- Path from outs_ready to ctrl_ready: combinational, as permitted by the elastic protocol.
- Path from ctrl_valid to ctrl_ready: combinational, through the grant.
- Requesters keep ctrl_valid asserted until ready; no requester may retract a valid.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

## Timing
- Reset (asynchronous, immediate):
  - full=0, so outs_valid=0.
  - data_q=0, so outs=0.
  - tag_q=0, so outs_tag=0.
  - prio=0.
  - ctrl_ready=0, because grant requires ctrl_valid and ctrl_valid is ignored while rst is high.
- Reset mid-operation: a pending output is discarded and nothing is replayed after reset.
- Latency: an accept in cycle N gives outs_valid=1 in cycle N+1.
- Throughput: one token per cycle while outs_ready=1. The slot is refilled in the same cycle it drains.
- Full slot with outs_ready=0:
  - All ctrl_ready bits are 0.
  - outs, outs_tag and outs_valid hold stable until accepted.
- Simultaneous drain and accept: the new constant replaces the old one. full stays 1.
- Pointer wrap: a winner NUM_REQ-1 sets prio=0.
- Empty slot with no request: the state holds.

## Test plan
Configuration for all scenarios unless noted:
- DATA_WIDTH=10, NUM_REQ=3, TAG_WIDTH=2.
- Constants: constant 0 = 10'b1110110110 (950), constant 1 = 7, constant 2 = 1023.

Scenarios:
1. Reset and idle:
   - Stimulus: assert rst asynchronously mid-cycle with ctrl_valid=3'b111.
   - Response: immediately outs_valid=0, outs=0, outs_tag=0, ctrl_ready=0.
   - Then: after release, the first grant goes to requester 0.
2. Single requester, back-to-back:
   - Stimulus: ctrl_valid=3'b010 for 4 cycles, outs_ready=1.
   - Response: outs=7, outs_tag=1, outs_valid=1 from cycle 1 to cycle 4.
   - Also: ctrl_ready=3'b010 every cycle.
3. Round-robin:
   - Stimulus: ctrl_valid=3'b111 held, outs_ready=1.
   - Response: output sequence 950/0, 7/1, 1023/2, 950/0, …
   - Also: prio wraps to 0 after requester 2.
4. Backpressure:
   - Stimulus: accept requester 2, then outs_ready=0 for 3 cycles with ctrl_valid=3'b001.
   - Response: outs=1023, outs_tag=2 held stable; ctrl_ready=0 for those 3 cycles.
   - Then: set outs_ready=1. In that same cycle, ctrl_ready[0]=1. Next cycle, outs=950, outs_tag=0.
5. Priority skip:
   - Stimulus: prio=1 with ctrl_valid=3'b101.
   - Response: requester 2 is granted, then prio=0, and requester 0 is granted next.
6. Drain without refill:
   - Stimulus: slot full, outs_ready=1, ctrl_valid=0.
   - Response: outs_valid drops to 0 the next cycle; outs holds its last value; prio is unchanged.
